// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT back-end constants and state encodings
package fft_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int N_POINTS   = 64;
    localparam int ADDR_WIDTH = 6;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/fft_output_reorder_serializer_if.sv
// rtl/fft_output_reorder_serializer_if.sv - input/output stream bundle for the reorder serializer
// slave  : block side (accepts in_*, produces out_*, frame_done)
// master : environment side (drives in_*, out_ready)
interface fft_output_reorder_serializer_if #(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_re;
    logic [DATA_WIDTH-1:0] in_im;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_re;
    logic [DATA_WIDTH-1:0] out_im;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;
    logic                  frame_done;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last, frame_done
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last, frame_done
    );
endinterface

// File: rtl/bit_reverse.sv
// rtl/bit_reverse.sv - combinational index bit reversal
// idx_in  : index to reverse
// idx_out : idx_in with bit order mirrored
module bit_reverse #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic [ADDR_WIDTH-1:0] idx_in,
    output logic [ADDR_WIDTH-1:0] idx_out
);
    always_comb begin
        idx_out = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            idx_out[i] = idx_in[ADDR_WIDTH-1-i];
        end
    end
endmodule

// File: rtl/dff_hold_sync_high_reset.sv
// rtl/dff_hold_sync_high_reset.sv - register with hold enable and synchronous active-high reset
// clk, rst : clock, synchronous active-high reset (clears q)
// hold     : keep current value when high
// d, q     : data in / registered data out
module dff_hold_sync_high_reset #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (!hold) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/fft_output_reorder_serializer.sv
// rtl/fft_output_reorder_serializer.sv - captures a bit-reversed FFT frame, replays it in natural order
// clk, rst : clock, synchronous active-high reset
// bus      : slave modport; in_* capture stream, out_* replay stream, frame_done pulse
// FFT_OUT_BITREV_EN : defined -> write address is bitrev(arrival count); undefined -> arrival count
module fft_output_reorder_serializer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int N_POINTS   = fft_pkg::N_POINTS,
    parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    fft_output_reorder_serializer_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_POINTS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    // rd_cnt wraps to 0 after the last read, so this flag marks "all words read"
    logic                    rd_done_q, rd_done_d;
    logic                    frame_done_q, frame_done_d;

    logic [2*DATA_WIDTH-1:0] buf_q [N_POINTS];
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;

    logic                    out_valid, out_last;
    logic [ADDR_WIDTH-1:0]   out_index;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic                    out_valid_d, out_last_d;
    logic [ADDR_WIDTH-1:0]   out_index_d;
    logic [2*DATA_WIDTH-1:0] out_data_d;

    logic in_fire, out_fire, hold, load_en;

`ifdef FFT_OUT_BITREV_EN
    bit_reverse #(.ADDR_WIDTH(ADDR_WIDTH)) u_bitrev (
        .idx_in  (wr_cnt_q),
        .idx_out (wr_addr)
    );
`else
    assign wr_addr = wr_cnt_q;
`endif

    assign bus.in_ready = (state_q == LOAD);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid && bus.out_ready;
    assign hold         = out_valid && !bus.out_ready;
    assign load_en      = (state_q == DRAIN) && !rd_done_q && (!out_valid || bus.out_ready);
    assign rd_data      = buf_q[rd_cnt_q];

    always_ff @(posedge clk) begin
        if (in_fire) buf_q[wr_addr] <= {bus.in_re, bus.in_im};
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_done_d    = rd_done_q;
        frame_done_d = out_fire && out_last;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (load_en) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) rd_done_d = 1'b1;
                end
                if (out_fire && out_last) begin
                    state_d   = LOAD;
                    rd_cnt_d  = '0;
                    rd_done_d = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Output register next values; the hold path inside the registers covers backpressure
    always_comb begin
        out_valid_d = load_en;
        out_last_d  = out_last;
        out_index_d = out_index;
        out_data_d  = out_data;
        if (load_en) begin
            out_last_d  = (rd_cnt_q == LAST_IDX);
            out_index_d = rd_cnt_q;
            out_data_d  = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_done_q    <= rd_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    dff_hold_sync_high_reset #(.WIDTH(1)) u_valid_reg (
        .clk(clk), .rst(rst), .hold(hold), .d(out_valid_d), .q(out_valid)
    );
    dff_hold_sync_high_reset #(.WIDTH(1)) u_last_reg (
        .clk(clk), .rst(rst), .hold(hold), .d(out_last_d), .q(out_last)
    );
    dff_hold_sync_high_reset #(.WIDTH(ADDR_WIDTH)) u_index_reg (
        .clk(clk), .rst(rst), .hold(hold), .d(out_index_d), .q(out_index)
    );
    dff_hold_sync_high_reset #(.WIDTH(2*DATA_WIDTH)) u_data_reg (
        .clk(clk), .rst(rst), .hold(hold), .d(out_data_d), .q(out_data)
    );

    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.out_index  = out_index;
    assign bus.out_re     = out_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.out_im     = out_data[DATA_WIDTH-1:0];
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/fft_output_reorder_serializer.md
Name: fft_output_reorder_serializer

Overview:
- Sink-side reader at the FFT back end. Captures one 64-point frame of complex results, which arrive in bit-reversed order.
- Replays the frame in natural order over a valid/ready stream.
- Downstream backpressure holds the output word stable. This is the consumer end of the hold-register path used inside the datapath.

Parameters:
- DATA_WIDTH, 16, width of each real/imag component
- N_POINTS, 64, frame length (power of two)
- ADDR_WIDTH, 6, log2(N_POINTS)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block accepts input (LOAD state)
- in_re  input  DATA_WIDTH  input real part
- in_im  input  DATA_WIDTH  input imaginary part
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts output
- out_re  output  DATA_WIDTH  output real part
- out_im  output  DATA_WIDTH  output imaginary part
- out_index  output  ADDR_WIDTH  natural-order index of the current output
- out_last  output  1  high with index N_POINTS-1
- frame_done  output  1  one-cycle pulse after the last output handshake

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=LOAD, wr_cnt=0, rd_cnt=0, in_ready=1, out_valid=0, out_re/out_im/out_index=0, out_last=0, frame_done=0. Buffer contents are not reset.
- Input handshake: a sample transfers when in_valid && in_ready.
  - Sample k (arrival count wr_cnt) is written to buffer[bitrev(k)].
  - wr_cnt increments on each transfer.
- State LOAD:
  - in_ready=1.
  - When the transfer with wr_cnt=N_POINTS-1 occurs: wr_cnt wraps to 0, state goes to DRAIN next cycle, and in_ready drops that same next cycle.
- State DRAIN:
  - in_ready=0.
  - Output register load enable = !out_valid || out_ready.
  - When enabled and rd_cnt<N_POINTS, the register loads buffer[rd_cnt], out_index=rd_cnt, out_last=(rd_cnt==N_POINTS-1). out_valid is set and rd_cnt increments.
  - First out_valid appears 1 cycle after entering DRAIN.
- Hold rule: while out_valid && !out_ready, all out_* hold their values (no change, no read advance).
- Drain end:
  - On handshake with out_last=1: out_valid=0 next cycle, frame_done pulses that cycle, rd_cnt=0, state returns to LOAD, in_ready=1.
  - Sustained throughput is 1 sample/cycle with out_ready held high.
- Simultaneous events: in_valid during DRAIN is ignored (not accepted, no write).
- Reset mid-operation discards the partial frame; counters and state return to the reset values on the next edge.
- Arithmetic: counters are ADDR_WIDTH wide and wrap naturally. No data arithmetic; data passes bit-exact.

Optional Feature:
- Macro: FFT_OUT_BITREV_EN
- Defined: write address = bitrev(wr_cnt), i.e. reorder as above.
- Undefined: write address = wr_cnt, so the block acts as a pure frame buffer/serializer with natural-order passthrough. All timing and handshakes are identical.

Decomposition:
- Shared package/include fft_pkg:
  - N_POINTS, ADDR_WIDTH, DATA_WIDTH defaults
  - state encodings LOAD=1'b0, DRAIN=1'b1
- Sub-module bit_reverse (parameter ADDR_WIDTH): pure combinational index reversal, reused elsewhere in the FFT.
- Output register built from existing dff_hold_sync_high_reset instances, with hold = out_valid && !out_ready.

Test Plan:
- Ramp frame: in_re=k, in_im=-k for k=0..63, out_ready=1 → output sequence in_re 0,32,16,48,8,40,… i.e. in_re=bitrev(j) at index j. out_last only at j=63; one frame_done pulse.
- Backpressure: drop out_ready for 5 cycles at j=10 → out_re/out_index frozen at 10's values, no skipped or repeated index after release.
- Input gaps: in_valid toggling 1/0 every cycle → frame still completes after 64 accepted samples. DRAIN starts the cycle after the 64th transfer.
- Input during drain: in_valid=1 throughout DRAIN → in_ready=0, buffer unchanged, and the second frame is accepted only after frame_done.
- Reset mid-drain at j=20 → next cycle out_valid=0, in_ready=1; a fresh frame reorders correctly.
- Macro undefined build: ramp input → output in_re=j at index j.
